// File: rtl/tcdm_pkg.sv
// Shared TCDM bank-port definitions: request layout, byte-enable constants
// and the byte-merge helper used by read-modify-write stores.
package tcdm_pkg;

  localparam int unsigned DataWidth    = 32;
  localparam int unsigned BeWidth      = DataWidth / 8;
  localparam int unsigned AddrMemWidth = 12;

  localparam logic [BeWidth-1:0] BeAllOnes = {BeWidth{1'b1}};

  // One bank request as seen at the bank port; also usable by the
  // interconnect when it aggregates request fields.
  typedef struct packed {
    logic                    wen;   // 0 = store, 1 = load
    logic [BeWidth-1:0]      be;
    logic [AddrMemWidth-1:0] addr;
    logic [DataWidth-1:0]    wdata;
  } tcdm_req_t;

  // Replace the bytes of old_word selected by be with those of new_word.
  function automatic logic [DataWidth-1:0] be_merge(
    input logic [DataWidth-1:0] old_word,
    input logic [DataWidth-1:0] new_word,
    input logic [BeWidth-1:0]   be
  );
    logic [DataWidth-1:0] res;
    res = old_word;
    for (int b = 0; b < BeWidth; b++) begin
      if (be[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/tcdm_bank_rmw.sv
// TCDM bank responder over a word-only 1R1W SRAM. Loads return data one
// cycle after the request; byte-enabled stores are turned into a two-stage
// read-modify-write with one level of write-back forwarding, never stalling.
module tcdm_bank_rmw
  import tcdm_pkg::*;
#(
  parameter int unsigned DataWidth    = tcdm_pkg::DataWidth,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = tcdm_pkg::AddrMemWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cs_i,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    mem_ren_o,
  output logic [AddrMemWidth-1:0] mem_raddr_o,
  input  logic [DataWidth-1:0]    mem_rdata_i,
  output logic                    mem_we_o,
  output logic [AddrMemWidth-1:0] mem_waddr_o,
  output logic [DataWidth-1:0]    mem_wdata_o
);

  // Stage-1 request and write-back register.
  logic                    s1_vld_q, s1_vld_d;
  tcdm_req_t               s1_req_q, s1_req_d;
  logic                    wb_vld_q, wb_vld_d;
  logic [AddrMemWidth-1:0] wb_addr_q, wb_addr_d;
  logic [DataWidth-1:0]    wb_data_q, wb_data_d;

  logic                    s1_ld, s1_st, s1_rmw;
  logic [DataWidth-1:0]    base_word;
  logic [DataWidth-1:0]    merged_word;

  // Stage 0: read the SRAM for loads and partial stores; full stores skip it.
  assign mem_ren_o   = cs_i & (wen_i | (be_i != BeAllOnes));
  assign mem_raddr_o = add_i;

  // Stage-1 capture: valid only when a request was presented.
  always_comb begin
    s1_vld_d       = cs_i;
    s1_req_d.wen   = wen_i;
    s1_req_d.be    = be_i;
    s1_req_d.addr  = add_i;
    s1_req_d.wdata = wdata_i;
  end

  // Stage 1: pick the base word, merge the store and drive the responses.
  always_comb begin
    // NOTE: every signal written here is given a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    s1_ld       = s1_vld_q & s1_req_q.wen;
    s1_st       = s1_vld_q & ~s1_req_q.wen;
    s1_rmw      = s1_st & (s1_req_q.be != BeAllOnes);

    // The SRAM is read-first, so a word written in the previous cycle comes
    // back stale; the write-back register holds the fresh copy.
    base_word   = (wb_vld_q && (wb_addr_q == s1_req_q.addr)) ? wb_data_q : mem_rdata_i;
    merged_word = s1_rmw ? be_merge(base_word, s1_req_q.wdata, s1_req_q.be)
                         : s1_req_q.wdata;

    rdata_o     = s1_ld ? base_word : '0;
    mem_we_o    = s1_st;
    mem_waddr_o = s1_req_q.addr;
    mem_wdata_o = merged_word;

    wb_vld_d    = s1_st;
    wb_addr_d   = s1_req_q.addr;
    wb_data_d   = merged_word;
  end

  // Control valids: cleared asynchronously so a pending store is dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_vld_q <= 1'b0;
      wb_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      wb_vld_q <= wb_vld_d;
    end
  end

  // Datapath registers: only meaningful when their valid is set.
  always_ff @(posedge clk_i) begin
    // NOTE: payload registers carry no reset; their valids gate every use,
    // which keeps reset fan-out on the control bits only.
    s1_req_q  <= s1_req_d;
    wb_addr_q <= wb_addr_d;
    wb_data_q <= wb_data_d;
  end

endmodule

// File: doc/tcdm_bank_rmw.md
Name: tcdm_bank_rmw

Overview:
- Bank-side responder for one TCDM bank port of the logarithmic/butterfly interconnect.
- Accepts the always-ready, fixed one-cycle-latency bank request (cs/add/wen/wdata/be) and returns rdata in the following cycle.
- Backs the port with a word-granular 1R1W SRAM macro that has no byte enables.
- Byte-enabled stores become a pipelined read-modify-write with write-after-write and read-after-write forwarding, so the bank never stalls.

Parameters:
- DataWidth, 32, word width.
- BeWidth, DataWidth/8, byte enables per word.
- AddrMemWidth, 12, word address bits per bank.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- cs_i  input  1  bank chip select; one request per cycle, always accepted.
- add_i  input  AddrMemWidth  word address.
- wen_i  input  1  request type: 0 = store, 1 = load.
- wdata_i  input  DataWidth  store data.
- be_i  input  BeWidth  byte enables.
- rdata_o  output  DataWidth  load response, valid the cycle after the load's cs_i.
- mem_ren_o  output  1  SRAM read-port enable.
- mem_raddr_o  output  AddrMemWidth  SRAM read address.
- mem_rdata_i  input  DataWidth  SRAM read data; one cycle after mem_ren_o; read-first on same-cycle write.
- mem_we_o  output  1  SRAM write-port enable.
- mem_waddr_o  output  AddrMemWidth  SRAM write address.
- mem_wdata_o  output  DataWidth  SRAM write data, full word.

Behaviour:
- Stage 0 (cycle N, cs_i=1), all outputs combinational:
  - mem_ren_o = cs_i & (wen_i | be_i != all-ones).
  - mem_raddr_o = add_i.
  - A full-word store issues no read.
- Stage-1 register, captured at the edge ending N when cs_i=1, else cleared:
  - s1_ld = wen_i; s1_st = ~wen_i; s1_rmw = ~wen_i & (be_i != all-ones).
  - s1_addr, s1_wdata, s1_be.
- Stage 1 (cycle N+1), base word selection:
  - base = wb_vld & (wb_addr == s1_addr) ? wb_data : mem_rdata_i.
  - Reason: the write-back register (wb_*) holds the word written in cycle N. The SRAM is read-first, so the cycle-N read returned stale data.
- Load in stage 1: rdata_o = base. Otherwise rdata_o = 0.
- Store in stage 1:
  - merged byte b = s1_be[b] ? s1_wdata[b] : base[b]; non-RMW stores use s1_wdata directly.
  - mem_we_o = 1, mem_waddr_o = s1_addr, mem_wdata_o = merged.
  - wb_vld <= 1, wb_addr <= s1_addr, wb_data <= merged.
- Cycles with no stage-1 store: mem_we_o = 0 and wb_vld <= 0.
- One forwarding level is sufficient: writes from cycle N-1 or earlier are committed before any cycle-N read.
- Every store uses the write port exactly at N+1, so sustained back-to-back stores, full or partial, never conflict and never stall.
- Latency: load data at N+1; store visible to a load issued at N+1 or later.
- Same-address store followed by store: the second store merges onto the forwarded first result.
- Load of a different address than wb_addr: no forwarding; SRAM data is returned.
- Idle cycles (cs_i=0): stage 1 cleared; mem_we_o=0 and rdata_o=0 next cycle.
- Reset, asynchronous and active-low:
  - Clears s1_* valids and wb_vld, so mem_we_o=0 and rdata_o=0 immediately.
  - A store captured in stage 1 when reset asserts is dropped and never written.
  - mem_ren_o stays combinational; the interconnect must hold cs_i=0 during reset.
- Widths: addresses compare exactly on AddrMemWidth bits; no wrap handling is needed.

Decomposition:
- Shared package tcdm_pkg holds:
  - bank request typedef (wen, be, addr, wdata), reusable by the interconnect's data aggregation;
  - constant BeAllOnes;
  - function be_merge(old, new, be).
- No sub-module: the stage-1 register, write-back register and merge logic fit in one module.

Test Plan:
- Reset: rst_ni=0 while a store sits in stage 1 -> mem_we_o=0 and rdata_o=0 in the same cycle; SRAM contents unchanged.
- Full store 0x010 <- 0xDEADBEEF, be=0xF -> mem_ren_o=0 at N; at N+1 mem_we_o=1, waddr=0x010, wdata=0xDEADBEEF; load 0x010 at N+3 -> rdata_o=0xDEADBEEF at N+4.
- Partial store 0x010 <- 0x00001234, be=0x3, over 0xDEADBEEF -> mem_ren_o=1 at N; mem_wdata_o=0xDEAD1234 at N+1.
- Back-to-back partial stores to 0x010 (over 0xDEADBEEF): be=0x1 data 0xAA at N, then be=0x2 data 0xBB00 at N+1 -> writes 0xDEADBEAA, then 0xDEADBBAA using the forwarded word; load at N+3 returns 0xDEADBBAA.
- Store-then-load hazard: full store 0x020 <- 0x11111111 at N, load 0x020 at N+1, with the SRAM model returning old 0x0 -> rdata_o=0x11111111 at N+2.
- No false forward: store 0x020 at N, load 0x030 (holds 0xCAFEF00D) at N+1 -> rdata_o=0xCAFEF00D at N+2.
- Random stream: 10k random cs/wen/be/addr against a byte-level reference model -> no rdata mismatch and exactly one mem_we_o per store.
